// File: rtl/fetch_stage_if.sv
// fetch_stage_if: icache request/response, decode control and fd slot signals
// of the instruction-fetch stage, with fetch-side (master) and environment (slave) views.
`default_nettype none

interface fetch_stage_if;
  logic        dcache_stall;
  logic        mul_stall;
  logic        load_stall;
  logic        branch_stall;
  logic        branch_en;
  logic [31:0] branch_PC;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_rdata;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        icache_stall;

  modport master (
    input  dcache_stall, mul_stall, load_stall, branch_stall, branch_en, branch_PC,
    input  ic_ready, ic_rdata,
    output ic_req, ic_addr, fd_pc, fd_instr, icache_stall
  );

  modport slave (
    output dcache_stall, mul_stall, load_stall, branch_stall, branch_en, branch_PC,
    output ic_ready, ic_rdata,
    input  ic_req, ic_addr, fd_pc, fd_instr, icache_stall
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, issues in-order icache requests, buffers
// responses in a prefetch queue and drives the fd pipeline slot toward decode.
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic     clock,
  input  wire logic     reset,
  fetch_stage_if.master bus
);
  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_ic_req;
  logic [31:0]   r_ic_addr;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_fd_valid;
  logic [31:0]   r_fd_pc;
  logic [31:0]   r_fd_instr;

  logic          w_freeze, w_hs, w_redirect, w_consume, w_resp_ok;
  logic          w_fd_load, w_q_empty, w_deq, w_bypass, w_enq;
  logic          w_pending_nxt, w_can_issue;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_pc_inc;

  always_comb begin
    w_freeze      = bus.dcache_stall | bus.mul_stall;
    w_hs          = r_ic_req & bus.ic_ready;
    w_redirect    = r_fd_valid & ~w_freeze & bus.branch_en;
    w_consume     = r_fd_valid & ~w_freeze & ~bus.load_stall & ~bus.branch_stall & ~bus.branch_en;
    // A response landing in SQUASH, or on the redirect edge itself, is wrong-path.
    w_resp_ok     = w_hs & (r_state != S_SQUASH) & ~w_redirect;
    w_fd_load     = (~r_fd_valid & ~w_freeze) | w_consume;
    w_q_empty     = (r_count == '0);
    w_deq         = w_fd_load & ~w_q_empty;
    w_bypass      = w_fd_load & w_q_empty & w_resp_ok;
    w_enq         = w_resp_ok & ~w_bypass;
    w_count_nxt   = w_redirect ? '0 : (r_count + CW'(w_enq) - CW'(w_deq));
    w_pending_nxt = r_ic_req & ~bus.ic_ready;
    // Only issue when the response is guaranteed a queue slot.
    w_can_issue   = ~w_freeze & ~w_pending_nxt & (w_count_nxt < C_DEPTH);
    w_pc_inc      = r_fetch_pc + 32'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_ic_req   <= 1'b0;
      r_ic_addr  <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= bus.branch_PC;
      if (w_pending_nxt) begin
        r_state <= S_SQUASH;
      end else begin
        r_state   <= S_FETCH;
        r_ic_req  <= w_can_issue;
        r_ic_addr <= bus.branch_PC;
      end
    end else begin
      case (r_state)
        S_SQUASH: begin
          if (bus.ic_ready) begin
            r_ic_req  <= w_can_issue;
            r_ic_addr <= r_fetch_pc;
            r_state   <= w_can_issue ? S_FETCH : S_HOLD;
          end
        end
        default: begin
          if (w_hs) r_fetch_pc <= w_pc_inc;
          if (!w_pending_nxt) begin
            r_ic_req  <= w_can_issue;
            r_ic_addr <= w_hs ? w_pc_inc : r_fetch_pc;
            r_state   <= w_can_issue ? S_FETCH : S_HOLD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]    <= r_ic_addr;
      r_q_instr[r_wr_ptr] <= bus.ic_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fd_valid <= 1'b0;
      r_fd_pc    <= 32'h0;
      r_fd_instr <= NOP_INSTR;
    end else if (w_redirect) begin
      r_fd_valid <= 1'b0;
      r_fd_pc    <= 32'h0;
      r_fd_instr <= NOP_INSTR;
    end else if (w_fd_load) begin
      if (w_deq) begin
        r_fd_valid <= 1'b1;
        r_fd_pc    <= r_q_pc[r_rd_ptr];
        r_fd_instr <= r_q_instr[r_rd_ptr];
      end else if (w_bypass) begin
        r_fd_valid <= 1'b1;
        r_fd_pc    <= r_ic_addr;
        r_fd_instr <= bus.ic_rdata;
      end else begin
        r_fd_valid <= 1'b0;
        r_fd_instr <= NOP_INSTR;
      end
    end
  end

  assign bus.ic_req       = r_ic_req;
  assign bus.ic_addr      = r_ic_addr;
  assign bus.fd_pc        = r_fd_pc;
  assign bus.fd_instr     = r_fd_instr;
  assign bus.icache_stall = ~r_fd_valid;
endmodule

`default_nettype wire
